// File: rtl/alu_mul_unit.sv
// A/B register pair with multi-op ALU, latched C/Z/N flags and shift-add multiplier on a shared bus.
// Latency: ALU result/bus drive combinational; registers/flags one edge; multiply WIDTH edges after start.
// Backpressure: busy high while multiplying; register loads, flag latches and mul_start ignored meanwhile.
module alu_mul_unit #(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic             clock,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] bus,
  input  logic             a_in,
  input  logic             a_out,
  input  logic             a_clear,
  input  logic             b_in,
  input  logic             b_out,
  input  logic             b_clear,
  input  logic [2:0]       alu_op,
  input  logic             alu_out,
  input  logic             flags_in,
  input  logic             mul_start,
  output logic             busy,
  output logic             mul_done,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             neg_flag
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mul_state_t;

  mul_state_t         state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   mcand_q, mplier_q;
  logic [2*WIDTH-1:0] acc_q, acc_next, mcand_ext;
  logic [CW-1:0]      count_q;
  logic               mul_done_q;
  logic               c_q, z_q, n_q;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   result;
  logic               alu_c;
  logic               start_go, last_iter;
  logic               drv_en;
  logic [WIDTH-1:0]   drv_val;

  assign start_go  = (MUL_EN != 0) && mul_start && (state_q == IDLE);
  assign last_iter = (state_q == RUN) && (count_q == LAST_CNT);
  assign busy      = (state_q == RUN);
  assign mul_done  = mul_done_q;
  assign carry_flag = c_q;
  assign zero_flag  = z_q;
  assign neg_flag   = n_q;

  // ALU: one WIDTH+1 sum covers add/sub/carry variants; C on subtract means "no borrow"
  always_comb begin
    sum    = '0;
    result = '0;
    alu_c  = 1'b0;
    case (alu_op)
      3'b000: begin sum = {1'b0, a_q} + {1'b0, b_q};                              result = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
      3'b001: begin sum = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(1);             result = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
      3'b010: begin sum = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(c_q);            result = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
      3'b011: begin sum = {1'b0, a_q} + {1'b0, ~b_q} + (WIDTH+1)'(c_q);           result = sum[WIDTH-1:0]; alu_c = sum[WIDTH]; end
      3'b100: result = a_q & b_q;
      3'b101: result = a_q | b_q;
      3'b110: result = a_q ^ b_q;
      default: begin result = {a_q[WIDTH-2:0], 1'b0}; alu_c = a_q[WIDTH-1]; end
    endcase
  end

  // Bus grant: a_out beats b_out beats alu_out, so at most one source ever drives
  always_comb begin
    drv_en  = 1'b1;
    drv_val = '0;
    if (a_out)        drv_val = a_q;
    else if (b_out)   drv_val = b_q;
    else if (alu_out) drv_val = result;
    else              drv_en  = 1'b0;
  end

  assign bus = drv_en ? drv_val : {WIDTH{1'bz}};

  // Multiplier partial sum for this iteration; on the last iteration this is the full product
  always_comb begin
    mcand_ext = {{WIDTH{1'b0}}, mcand_q};
    acc_next  = acc_q;
    if (mplier_q[0]) acc_next = acc_q + (mcand_ext << count_q);
  end

  // Multiplier FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Multiplier FSM next state: IDLE -> RUN on start, RUN -> IDLE after the WIDTH-th iteration
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_go)  state_d = RUN;
      RUN:     if (last_iter) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registers, flags and multiplier datapath; a finishing multiply owns A/B/flags that edge
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= 1'b0;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      mul_done_q <= 1'b0;
    end else begin
      mul_done_q <= 1'b0;
      if (state_q == RUN) begin
        if (last_iter) begin
          a_q        <= acc_next[WIDTH-1:0];
          b_q        <= acc_next[2*WIDTH-1:WIDTH];
          z_q        <= (acc_next == '0);
          c_q        <= (acc_next[2*WIDTH-1:WIDTH] != '0);
          n_q        <= acc_next[2*WIDTH-1];
          mul_done_q <= 1'b1;
        end else begin
          acc_q    <= acc_next;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + CW'(1);
        end
      end else begin
        if (start_go) begin
          mcand_q  <= a_q;
          mplier_q <= b_q;
          acc_q    <= '0;
          count_q  <= '0;
        end
        if (a_in)         a_q <= bus;
        else if (a_clear) a_q <= '0;
        if (b_in)         b_q <= bus;
        else if (b_clear) b_q <= '0;
        if (flags_in) begin
          c_q <= alu_c;
          z_q <= (result == '0);
          n_q <= result[WIDTH-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mul_unit.sv
// Directed bench for alu_mul_unit (WIDTH=8): ALU ops, flags, bus priority, multiply and abort.
// Latency: inputs change #1 after each rising edge; outputs sampled at that same point.
// Backpressure: busy-wait loops are bounded; an expired bound counts as an error.
module tb_alu_mul_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  wire  [7:0] bus;
  logic [7:0] tb_drv = 8'h00;
  logic       tb_en = 1'b0;
  logic       a_in = 0, a_out = 0, a_clear = 0;
  logic       b_in = 0, b_out = 0, b_clear = 0;
  logic [2:0] alu_op = 3'b000;
  logic       alu_out = 0, flags_in = 0, mul_start = 0;
  logic       busy, mul_done, carry_flag, zero_flag, neg_flag;

  int checks = 0;
  int errors = 0;
  int cnt;

  assign bus = tb_en ? tb_drv : 8'bz;

  always #5 clock = ~clock;

  alu_mul_unit #(.WIDTH(8), .MUL_EN(1)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .a_in(a_in), .a_out(a_out), .a_clear(a_clear),
    .b_in(b_in), .b_out(b_out), .b_clear(b_clear),
    .alu_op(alu_op), .alu_out(alu_out), .flags_in(flags_in),
    .mul_start(mul_start), .busy(busy), .mul_done(mul_done),
    .carry_flag(carry_flag), .zero_flag(zero_flag), .neg_flag(neg_flag)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_a(input logic [7:0] v);
    tb_drv = v; tb_en = 1'b1; a_in = 1'b1;
    tick();
    a_in = 1'b0; tb_en = 1'b0;
  endtask

  task automatic load_b(input logic [7:0] v);
    tb_drv = v; tb_en = 1'b1; b_in = 1'b1;
    tick();
    b_in = 1'b0; tb_en = 1'b0;
  endtask

  task automatic read_a(input string tag, input logic [7:0] exp);
    a_out = 1'b1; #1;
    check(tag, {8'h00, bus}, {8'h00, exp});
    a_out = 1'b0; #1;
  endtask

  task automatic read_b(input string tag, input logic [7:0] exp);
    b_out = 1'b1; #1;
    check(tag, {8'h00, bus}, {8'h00, exp});
    b_out = 1'b0; #1;
  endtask

  // Drive ALU onto the bus, compare, optionally latch flags on the next edge
  task automatic alu(input string tag, input logic [2:0] op, input logic [7:0] exp, input logic latch);
    alu_op = op; alu_out = 1'b1; #1;
    check(tag, {8'h00, bus}, {8'h00, exp});
    if (latch) begin
      flags_in = 1'b1;
      tick();
      flags_in = 1'b0;
    end
    alu_out = 1'b0; #1;
  endtask

  task automatic check_flags(input string tag, input logic c, input logic z, input logic n);
    check(tag, {13'd0, carry_flag, zero_flag, neg_flag}, {13'd0, c, z, n});
  endtask

  // Counts cycles with busy high, capped at 20
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 20) begin
      n++;
      tick();
    end
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, mul_done}, 16'd0);
    check_flags("rst_flags", 0, 0, 0);
    read_a("rst_a", 8'h00);
    read_b("rst_b", 8'h00);

    // ADD 5+3
    load_a(8'h05); load_b(8'h03);
    alu("add_5_3", 3'b000, 8'h08, 1);
    check_flags("add_5_3_flags", 0, 0, 0);

    // SUB 3-5 borrows
    load_a(8'h03); load_b(8'h05);
    alu("sub_3_5", 3'b001, 8'hFE, 1);
    check_flags("sub_3_5_flags", 0, 0, 1);

    // SUB equal operands
    load_a(8'h42); load_b(8'h42);
    alu("sub_eq", 3'b001, 8'h00, 1);
    check_flags("sub_eq_flags", 1, 1, 0);

    // ADD overflow then ADC picks up the carry
    load_a(8'hFF); load_b(8'h01);
    alu("add_ovf", 3'b000, 8'h00, 1);
    check_flags("add_ovf_flags", 1, 1, 0);
    a_clear = 1'b1; b_clear = 1'b1; tick(); a_clear = 1'b0; b_clear = 1'b0;
    read_a("clear_a", 8'h00);
    alu("adc_0_0", 3'b010, 8'h01, 0);

    // Logic ops and shift
    load_a(8'hC3); load_b(8'h5A);
    alu("and", 3'b100, 8'h42, 1);
    check_flags("and_flags", 0, 0, 0);
    alu("or",  3'b101, 8'hDB, 0);
    alu("xor", 3'b110, 8'h99, 0);
    alu("shl", 3'b111, 8'h86, 1);
    check_flags("shl_flags", 1, 0, 1);

    // SBC with carry set: 0x10 - 0x03 = 0x0D, no borrow
    load_a(8'h10); load_b(8'h03);
    alu("sbc", 3'b011, 8'h0D, 1);
    check_flags("sbc_flags", 1, 0, 0);

    // Multiply 0xFF * 0xFF = 0xFE01
    load_a(8'hFF); load_b(8'hFF);
    mul_start = 1'b1; tick(); mul_start = 1'b0;
    wait_idle(cnt);
    check("mul1_busy_cycles", 16'(cnt), 16'd8);
    check("mul1_done_hi", {15'd0, mul_done}, 16'd1);
    tick();
    check("mul1_done_lo", {15'd0, mul_done}, 16'd0);
    read_a("mul1_a", 8'h01);
    read_b("mul1_b", 8'hFE);
    check_flags("mul1_flags", 1, 0, 1);

    // Multiply 0x0D * 0x0B = 0x008F, with a_in and mul_start poked while busy
    load_a(8'h0D); load_b(8'h0B);
    mul_start = 1'b1; tick(); mul_start = 1'b0;
    check("mul2_busy", {15'd0, busy}, 16'd1);
    tb_drv = 8'h77; tb_en = 1'b1; a_in = 1'b1; mul_start = 1'b1;
    tick();
    a_in = 1'b0; tb_en = 1'b0; mul_start = 1'b0;
    read_a("busy_a_in_ignored", 8'h0D);
    wait_idle(cnt);
    check("mul2_busy_cycles", 16'(cnt), 16'd7);
    read_a("mul2_a", 8'h8F);
    read_b("mul2_b", 8'h00);
    check_flags("mul2_flags", 0, 0, 0);

    // Reset during the 4th iteration aborts the multiply
    load_a(8'h80);
    alu("shl_zero", 3'b111, 8'h00, 1);
    check_flags("pre_abort_flags", 1, 1, 0);
    load_a(8'hFF); load_b(8'hFF);
    mul_start = 1'b1; tick(); mul_start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("abort_busy", {15'd0, busy}, 16'd0);
    check_flags("abort_flags", 0, 0, 0);
    tb_drv = 8'hA5; tb_en = 1'b1; #1;
    check("abort_bus_z", {8'h00, bus}, 16'h00A5);
    tb_en = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    check("abort_stays_idle", {14'd0, busy, mul_done}, 16'd0);
    read_a("abort_a", 8'h00);
    read_b("abort_b", 8'h00);

    // Bus grant priority and in-over-clear priority
    load_a(8'h21); load_b(8'h10);
    alu_op = 3'b000; a_out = 1'b1; alu_out = 1'b1; #1;
    check("prio_a_over_alu", {8'h00, bus}, 16'h0021);
    a_out = 1'b0; b_out = 1'b1; #1;
    check("prio_b_over_alu", {8'h00, bus}, 16'h0010);
    b_out = 1'b0; #1;
    check("alu_only", {8'h00, bus}, 16'h0031);
    alu_out = 1'b0;
    tb_drv = 8'h5C; tb_en = 1'b1; a_in = 1'b1; a_clear = 1'b1;
    tick();
    a_in = 1'b0; a_clear = 1'b0; tb_en = 1'b0;
    read_a("in_over_clear", 8'h5C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
